// File: rtl/key_debounce_if.sv
// Key interface between the raw key pads and the tone logic.
//   key_in     : raw asynchronous key levels, 1 = pressed, bit i = key i+1
//   keys       : debounced key levels
//   press      : one-cycle strobe per key on debounced 0->1
//   rel        : one-cycle strobe per key on debounced 1->0
//                ("release" is a reserved word in SystemVerilog)
//   note       : index of the selected key
//   note_valid : 1 while the selected key is held
// master drives key_in and observes the results; slave is the debouncer.
interface key_debounce_if;
  logic [3:0] key_in;
  logic [3:0] keys;
  logic [3:0] press;
  logic [3:0] rel;
  logic [1:0] note;
  logic       note_valid;

  modport master (
    output key_in,
    input  keys, press, rel, note, note_valid
  );

  modport slave (
    input  key_in,
    output keys, press, rel, note, note_valid
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces four raw key levels, produces
// press/release strobes and a last-pressed-wins note selection.
//   clk : system clock (internal oscillator)
//   rst : synchronous active-high reset
//   bus : key_debounce_if.slave (key_in in; keys/press/rel/note/note_valid out)
// Parameters:
//   freq        : clock frequency in Hz
//   debounce_us : debounce window in microseconds
//   cntw        : per-key counter width, must hold limit-1
module key_debounce #(
  parameter int unsigned freq        = 133000000,
  parameter int unsigned debounce_us = 10000,
  parameter int unsigned cntw        = 21
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave bus
);

  localparam int unsigned cycles_per_us = freq / 1000000;
  localparam int unsigned raw_limit     = cycles_per_us * debounce_us;
  localparam int unsigned limit         = (raw_limit < 1) ? 1 : raw_limit;
  localparam logic [cntw-1:0] last      = cntw'(limit - 1);

  if ((64'(limit - 1) >> cntw) != 64'd0) begin : g_cntw_check
    $error("key_debounce: cntw too small to hold limit-1");
  end

  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [cntw-1:0] cnt [4];
  logic [3:0]      keys;
  logic [3:0]      press;
  logic [3:0]      rel;
  logic [1:0]      note;
  logic            note_valid;

  logic [1:0]      hi_press;
  logic [1:0]      lo_key;

  // Highest pressed index wins a simultaneous press; fallback after the
  // selected key is released is the lowest still-held key.
  always_comb begin
    hi_press = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (press[i]) hi_press = 2'(i);
    end
    lo_key = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (keys[i-1]) lo_key = 2'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      keys       <= '0;
      press      <= '0;
      rel        <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.key_in;
      sync2 <= sync1;
      press <= '0;
      rel   <= '0;

      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == keys[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == last) begin
          keys[i] <= sync2[i];
          cnt[i]  <= '0;
          if (sync2[i]) press[i] <= 1'b1;
          else          rel[i]   <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + cntw'(1);
        end
      end

      // Uses the registered keys/press, so selection lags the strobe by one edge.
      if (press != '0) begin
        note       <= hi_press;
        note_valid <= 1'b1;
      end else if (note_valid && !keys[note]) begin
        if (keys != '0) note       <= lo_key;
        else            note_valid <= 1'b0;
      end
    end
  end

  assign bus.keys       = keys;
  assign bus.press      = press;
  assign bus.rel        = rel;
  assign bus.note       = note;
  assign bus.note_valid = note_valid;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with limit = 4 (freq 1 MHz, 4 us).
// Inputs change 1 time unit after a rising edge (edge E0); checks are taken
// 1 time unit after the edge they refer to.
module tb_key_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  key_debounce_if kif ();

  key_debounce #(
    .freq        (1000000),
    .debounce_us (4),
    .cntw        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_keys"},  {4'b0, kif.keys},  8'h00);
    check({tag, "_press"}, {4'b0, kif.press}, 8'h00);
    check({tag, "_rel"},   {4'b0, kif.rel},   8'h00);
    check({tag, "_note"},  {6'b0, kif.note},  8'h00);
    check({tag, "_nv"},    {7'b0, kif.note_valid}, 8'h00);
  endtask

  int press_cnt, rel_cnt, press_at, rel_at;

  initial begin
    kif.key_in = 4'b0000;

    // 1: reset state, then single key press
    ticks(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    kif.key_in = 4'b0001;
    ticks(5);
    check("t1_keys_e5", {4'b0, kif.keys}, 8'h00);
    tick();
    check("t1_keys_e6",  {4'b0, kif.keys},  8'h01);
    check("t1_press_e6", {4'b0, kif.press}, 8'h01);
    check("t1_nv_e6",    {7'b0, kif.note_valid}, 8'h00);
    tick();
    check("t1_press_e7", {4'b0, kif.press}, 8'h00);
    check("t1_note_e7",  {6'b0, kif.note},  8'h00);
    check("t1_nv_e7",    {7'b0, kif.note_valid}, 8'h01);

    // 2a: 3-cycle glitch on key 2 is ignored
    press_cnt = 0; rel_cnt = 0;
    kif.key_in = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (kif.press != 0) press_cnt++;
      if (kif.rel != 0) rel_cnt++;
    end
    kif.key_in = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (kif.press != 0) press_cnt++;
      if (kif.rel != 0) rel_cnt++;
    end
    check("t2_glitch_keys",  {4'b0, kif.keys}, 8'h01);
    check("t2_glitch_press", 8'(press_cnt), 8'd0);
    check("t2_glitch_rel",   8'(rel_cnt),   8'd0);
    check("t2_glitch_note",  {5'b0, kif.note_valid, kif.note}, 8'h04);

    // 2b: 4-cycle pulse on key 2 is accepted
    press_cnt = 0; rel_cnt = 0; press_at = -1; rel_at = -1;
    kif.key_in = 4'b0101;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 4) kif.key_in = 4'b0001;
      if (kif.press == 4'b0100) begin press_cnt++; press_at = i; end
      else if (kif.press != 0) press_cnt += 10;
      if (kif.rel == 4'b0100) begin rel_cnt++; rel_at = i; end
      else if (kif.rel != 0) rel_cnt += 10;
    end
    check("t2_pulse_press_cnt", 8'(press_cnt), 8'd1);
    check("t2_pulse_press_at",  8'(press_at),  8'd6);
    check("t2_pulse_rel_cnt",   8'(rel_cnt),   8'd1);
    check("t2_pulse_rel_at",    8'(rel_at),    8'd10);
    check("t2_pulse_note",      {5'b0, kif.note_valid, kif.note}, 8'h04);

    // 3: key 0 held, key 2 pressed and released, then key 0 released
    kif.key_in = 4'b0101;
    ticks(6);
    check("t3_press2", {4'b0, kif.press}, 8'h04);
    tick();
    check("t3_note2", {5'b0, kif.note_valid, kif.note}, 8'h06);
    kif.key_in = 4'b0001;
    ticks(6);
    check("t3_rel2", {4'b0, kif.rel}, 8'h04);
    check("t3_note_still2", {5'b0, kif.note_valid, kif.note}, 8'h06);
    tick();
    check("t3_note_back0", {5'b0, kif.note_valid, kif.note}, 8'h04);
    kif.key_in = 4'b0000;
    ticks(6);
    check("t3_rel0", {4'b0, kif.rel}, 8'h01);
    tick();
    check("t3_nv_off", {5'b0, kif.note_valid, kif.note}, 8'h00);

    // 4: simultaneous press of keys 1 and 3
    kif.key_in = 4'b1010;
    ticks(6);
    check("t4_press", {4'b0, kif.press}, 8'h0a);
    check("t4_keys",  {4'b0, kif.keys},  8'h0a);
    tick();
    check("t4_note3", {5'b0, kif.note_valid, kif.note}, 8'h07);
    check("t4_press_clr", {4'b0, kif.press}, 8'h00);
    kif.key_in = 4'b0000;
    ticks(6);
    check("t4_rel", {4'b0, kif.rel}, 8'h0a);
    tick();
    check("t4_nv_off_note_kept", {5'b0, kif.note_valid, kif.note}, 8'h03);

    // 5: reset while key 1 is held
    kif.key_in = 4'b0010;
    ticks(7);
    check("t5_pre_keys", {4'b0, kif.keys}, 8'h02);
    check("t5_pre_note", {5'b0, kif.note_valid, kif.note}, 8'h05);
    rst = 1'b1;
    tick();
    check_all_zero("t5_rst1");
    tick();
    check_all_zero("t5_rst2");
    rst = 1'b0;
    ticks(5);
    check("t5_keys_e5", {4'b0, kif.keys}, 8'h00);
    tick();
    check("t5_keys_e6",  {4'b0, kif.keys},  8'h02);
    check("t5_press_e6", {4'b0, kif.press}, 8'h02);
    tick();
    check("t5_note1", {5'b0, kif.note_valid, kif.note}, 8'h05);
    kif.key_in = 4'b0000;
    ticks(7);
    check("t5_cleanup", {5'b0, kif.note_valid, kif.note}, 8'h01);

    // 6: bouncing key 3, then stable high
    press_cnt = 0; rel_cnt = 0; press_at = -1;
    for (int s = 0; s < 10; s++) begin
      kif.key_in = (s % 2 == 0) ? 4'b1000 : 4'b0000;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (kif.press != 0) press_cnt++;
        if (kif.rel != 0) rel_cnt++;
      end
    end
    kif.key_in = 4'b1000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (kif.press == 4'b1000) begin press_cnt++; press_at = i; end
      else if (kif.press != 0) press_cnt += 10;
      if (kif.rel != 0) rel_cnt++;
    end
    check("t6_press_cnt", 8'(press_cnt), 8'd1);
    check("t6_press_at",  8'(press_at),  8'd6);
    check("t6_rel_cnt",   8'(rel_cnt),   8'd0);
    check("t6_note3", {5'b0, kif.note_valid, kif.note}, 8'h07);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream stage of the piano tone logic.
- Takes the four raw active-high key levels (pad inputs already inverted at top level) and synchronises and debounces each one.
- Produces clean key levels, one-cycle press/release strobes, and a last-pressed-wins note selection that the tone generator consumes.
- Runs on the internal oscillator clock.

Parameters:
- freq, 133000000, clock frequency in Hz.
- debounce_us, 10000, debounce window in microseconds.
- cntw, 21, per-key debounce counter width; must hold limit-1.
- Derived: limit = max(1, (freq/1000000)*debounce_us) cycles (1330000 at defaults).

Ports:
- clk  input  1  system clock (internal oscillator).
- rst  input  1  synchronous active-high reset.
- key_in  input  4  raw key levels, asynchronous, 1 = pressed; bit i = key i+1.
- keys  output  4  debounced key levels.
- press  output  4  one-cycle strobe per key on debounced 0->1.
- release  output  4  one-cycle strobe per key on debounced 1->0.
- note  output  2  index of the selected key (0..3).
- note_valid  output  1  1 while a selected key is held.

Behaviour:
- One clock; reset is synchronous and active-high. rst sampled on clk rising edge sets all of the following to 0: sync flops, counters, keys, press, release, note, note_valid.
- Synchroniser: 2-FF per bit; sync = second stage.
- Debounce, per key i, each edge:
  - If sync[i]==keys[i]: cnt[i] <= 0.
  - Else if cnt[i]==limit-1: keys[i] <= sync[i], cnt[i] <= 0, and press[i] or release[i] <= 1 for exactly that one following cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Debounce latency: a clean step on key_in (meeting setup before edge E0) appears on keys after edge E(limit+2).
- Glitches: any bounce or glitch shorter than limit consecutive sampled cycles resets the count; keys does not change.
- Strobes: press and release are 0 in every other cycle. Both may be set for different bits in the same cycle.
- Note selection is registered from the registered keys/press values, so note and note_valid update one edge after the press/release strobe cycle. Priority:
  1. If press != 0: note <= highest index i with press[i]; note_valid <= 1.
  2. Else if note_valid and keys[note]==0: if keys != 0, note <= lowest set index in keys and note_valid stays 1; otherwise note_valid <= 0.
  3. Otherwise hold.
- note retains its last value when note_valid drops.
- Reset mid-operation: a key held through rst deassertion starts from keys=0 and re-debounces. It produces press and note_valid after limit+2 (+1 for note) cycles, the same as a fresh press.
- No wrap-around: cnt never exceeds limit-1. Implementation asserts cntw is sufficient at elaboration.

Test Plan (freq=1000000, debounce_us=4 -> limit=4, cntw=3):
1. Reset, then key_in=0001 held -> keys=0001 after edge 6 from the step; press=0001 for exactly 1 cycle; next edge note=0, note_valid=1.
2. key_in[2] pulses high for 3 cycles, then low -> keys, press and note unchanged. A 4-cycle pulse instead -> press[2] once, then release[2] once, 4+ cycles later.
3. Key 0 held and stable, then key 2 pressed -> note=2. Release key 2 -> release=0100, then note=0, note_valid=1. Release key 0 -> note_valid=0, note stays 0.
4. key_in=0000 -> 1010 on the same edge -> press=1010 in the same cycle; note=3, note_valid=1.
5. Key 1 debounced high; assert rst for 2 cycles with key_in=0010 held -> all outputs 0 during reset; keys[1] rises 6 edges after rst deasserts, with a press strobe; note=1 one edge later.
6. Bouncing key_in[3] (toggles every 2 cycles for 20 cycles, then stable high) -> exactly one press[3] strobe, 6 edges after the final stable transition; no release strobes.
